rr_arb_mux: RTL and testbench

Parametrised N-input, W-bit round-robin arbitrating multiplexer with valid/ready handshakes and a registered output stage. It is the clocked successor of the 4:1 operator-based mux: the select comes from a fair arbiter rather than external select lines. It sits wherever several producers share one downstream consumer, such as merging request streams onto a single bus.

---
 rtl/rr_arb_mux_pkg.sv | 15 +
 rtl/rr_arb_mux_pick.sv | 29 ++
 rtl/rr_arb_mux.sv | 134 +++++++++++++
 tb/tb_rr_arb_mux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating multiplexer.
// State encodings are used only when RR_ARB_MUX_LOCK_EN is defined.
package rr_arb_mux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   // Channel-index width; a single channel still needs one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Combinational rotating-priority encoder: first asserted request found
// when scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [SW-1:0] scan_idx;

   // Scan from lowest priority to highest so the highest-priority hit wins.
   always_comb begin
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      scan_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         scan_idx = SW'((int'(ptr) + k) % N);
         if (req[scan_idx]) begin
            gnt_idx = scan_idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrating mux with a registered valid/ready output.
// Define RR_ARB_MUX_LOCK_EN to keep a packet's beats together until in_last.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            in_valid,
   input  logic [N*W-1:0]          in_data,
   input  logic [N-1:0]            in_last,
   output logic [N-1:0]            in_ready,
   output logic                    out_valid,
   output logic [W-1:0]            out_data,
   output logic [sel_width(N)-1:0] out_sel,
   output logic                    out_last,
   input  logic                    out_ready
);

   localparam int SW = sel_width(N);

   logic [W-1:0]  chan_data [N];
   logic [SW-1:0] ptr_reg;
   logic [SW-1:0] ptr_next;
   logic [SW-1:0] pick_idx;
   logic          pick_any;
   logic [SW-1:0] grant_idx;
   logic          grant_any;
   logic          load;
   logic          xfer;

   logic          out_valid_reg;
   logic [W-1:0]  out_data_reg;
   logic [SW-1:0] out_sel_reg;
   logic          out_last_reg;

   rr_pick #(
      .N  (N),
      .SW (SW)
   ) u_pick (
      .req     (in_valid),
      .ptr     (ptr_reg),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

`ifdef RR_ARB_MUX_LOCK_EN
   arb_state_t    state_reg;
   logic [SW-1:0] lock_reg;

   // While a packet is open only its owner may be granted.
   always_comb begin
      grant_idx = pick_idx;
      grant_any = pick_any;
      if (state_reg == ST_LOCK) begin
         grant_idx = lock_reg;
         grant_any = in_valid[lock_reg];
      end
   end
`else
   assign grant_idx = pick_idx;
   assign grant_any = pick_any;
`endif

   assign load     = ~out_valid_reg | out_ready;
   // Reset gates the handshake so no channel sees ready while rst is high.
   assign xfer     = grant_any & load & ~rst;
   assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_chan
         assign chan_data[gi] = in_data[gi*W +: W];
         assign in_ready[gi]  = xfer & (grant_idx == SW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sel_reg   <= '0;
         out_last_reg  <= 1'b0;
         ptr_reg       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
         state_reg     <= ST_IDLE;
         lock_reg      <= '0;
`endif
      end else begin
         if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= chan_data[grant_idx];
            out_sel_reg   <= grant_idx;
            out_last_reg  <= in_last[grant_idx];
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end

`ifdef RR_ARB_MUX_LOCK_EN
         // The pointer only advances once a whole packet has gone through.
         if (xfer) begin
            case (state_reg)
               ST_IDLE: begin
                  if (!in_last[grant_idx]) begin
                     state_reg <= ST_LOCK;
                     lock_reg  <= grant_idx;
                  end else begin
                     ptr_reg   <= ptr_next;
                  end
               end
               ST_LOCK: begin
                  if (in_last[grant_idx]) begin
                     state_reg <= ST_IDLE;
                     ptr_reg   <= ptr_next;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
`else
         if (xfer) begin
            ptr_reg <= ptr_next;
         end
`endif
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sel   = out_sel_reg;
   assign out_last  = out_last_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a queue-based reference arbiter predicts
// each accepted beat; a separate monitor checks beats as they drain.
module tb_rr_arb_mux;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   typedef struct {
      int         sel;
      logic [W-1:0] data;
      logic       last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     chan_valid;
   logic [N-1:0]     chan_last;
   logic [W-1:0]     chan_data [N];
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [SW-1:0]    out_sel;
   logic             out_last;
   logic             out_ready;

   int               n_checks = 0;
   int               n_fail   = 0;
   beat_t            exp_q[$];
   logic [N-1:0]     acc = '0;

   // Reference model state
   int               m_ptr    = 0;
   bit               m_full   = 0;
   bit               m_locked = 0;
   int               m_lock_ch = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = chan_data[i];
   end

   rr_arb_mux #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (chan_valid),
      .in_data   (in_data),
      .in_last   (chan_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbiter: decides from the spec rules which channel the
   // coming clock edge accepts and pushes the predicted beat.
   initial begin
      int           g;
      bit           load;
      logic [N-1:0] exp_ready;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_out_sel", 32'(out_sel), 0);
            chk("rst_out_last", 32'(out_last), 0);
            m_ptr = 0; m_full = 0; m_locked = 0; m_lock_ch = 0;
            exp_q.delete();
            acc = '0;
         end else begin
            chk("out_valid", 32'(out_valid), 32'(m_full));
            load = !m_full || (out_ready === 1'b1);
            g = -1;
            if (load) begin
               if (m_locked) begin
                  if (chan_valid[m_lock_ch]) g = m_lock_ch;
               end else begin
                  for (int k = 0; k < N; k++)
                     if (g < 0 && chan_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
               end
            end
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            acc = exp_ready & chan_valid;
            if (g >= 0) begin
               exp_q.push_back('{sel: g, data: chan_data[g], last: chan_last[g]});
               m_full = 1;
`ifdef RR_ARB_MUX_LOCK_EN
               if (m_locked) begin
                  if (chan_last[g]) begin
                     m_locked = 0;
                     m_ptr = (g + 1) % N;
                  end
               end else if (!chan_last[g]) begin
                  m_locked = 1;
                  m_lock_ch = g;
               end else begin
                  m_ptr = (g + 1) % N;
               end
`else
               m_ptr = (g + 1) % N;
`endif
            end else if (out_ready) begin
               m_full = 0;
            end
         end
      end
   end

   // Monitor: checks held beats stay stable and pops on every drained beat.
   initial begin
      bit           prev_hold = 0;
      logic [W-1:0] prev_data = '0;
      logic [SW-1:0] prev_sel = '0;
      beat_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold = 0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", 32'(out_valid), 1);
               chk("hold_data", 32'(out_data), 32'(prev_data));
               chk("hold_sel", 32'(out_sel), 32'(prev_sel));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got sel=%0d data=%0h, expected no beat", out_sel, out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_sel", 32'(out_sel), 32'(e.sel));
                  chk("beat_data", 32'(out_data), 32'(e.data));
                  chk("beat_last", 32'(out_last), 32'(e.last));
                  $display("beat sel=%0d data=%02h last=%0b (exp sel=%0d data=%02h)",
                           out_sel, out_data, out_last, e.sel, e.data);
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_sel  = out_sel;
         end
      end
   end

   // One cycle of producer/consumer stimulus; producers hold until accepted.
   task automatic step(input logic [N-1:0] mask, input int prob, input bit fixed, input int rdy_pct);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) chan_valid[i] = 1'b0;
         if (!chan_valid[i] && mask[i] && int'($urandom_range(99)) < prob) begin
            chan_valid[i] = 1'b1;
            chan_data[i]  = fixed ? W'(8'hA0 + i) : W'($urandom);
            chan_last[i]  = fixed ? 1'b1 : 1'($urandom_range(1));
         end
      end
      out_ready = int'($urandom_range(99)) < rdy_pct;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_data", 32'(out_data), 0);
      chk("arst_out_sel", 32'(out_sel), 0);
      chk("arst_out_last", 32'(out_last), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      chan_valid = '1;
      chan_last  = '1;
      for (int i = 0; i < N; i++) chan_data[i] = W'(8'hA0 + i);
      out_ready  = 1'b1;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;

      // Fairness: all channels valid, drain every cycle.
      repeat (8) step(4'b1111, 100, 1, 100);
      // Idle / drain.
      repeat (6) step(4'b0000, 0, 1, 100);
      // Move pointer to 2 with a lone ch1 beat, then ch1/ch3 wrap pattern.
      step(4'b0010, 100, 1, 100);
      repeat (5) step(4'b1010, 100, 1, 100);
      repeat (5) step(4'b0000, 0, 1, 100);
      // Backpressure for three cycles after a load, then release.
      repeat (4) step(4'b1111, 100, 1, 0);
      repeat (3) step(4'b1111, 100, 1, 100);
      // Hold a beat, then reset asynchronously mid-transfer.
      repeat (2) step(4'b1111, 100, 1, 0);
      async_reset();
      // Randomised traffic.
      repeat (3000) step(4'b1111, 50, 0, 70);
      repeat (30) step(4'b0000, 0, 0, 100);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
